// File: rtl/sram_dp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_dp_ctrl_if
//  Description : Client-side bus of the dual-port SRAM controller.
//                Two independent valid/ready request channels plus their
//                read-return channels (rvalid pulse + rdata).
//                  req*    client request valid
//                  we*     1 = write, 0 = read
//                  addr*   13-bit word address
//                  wdata*  32-bit write data
//                  ready*  request accepted when req & ready
//                  rvalid* one-cycle read-return pulse
//                  rdata*  read data, valid while rvalid* is high
//                The controller connects through the slave modport and the
//                clients through the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_dp_ctrl_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [12:0] addr0;
    logic [12:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ready0;
    logic        ready1;
    logic        rvalid0;
    logic        rvalid1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ready0, ready1, rvalid0, rvalid1, rdata0, rdata1
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ready0, ready1, rvalid0, rvalid1, rdata0, rdata1
    );
endinterface
`default_nettype wire

// File: rtl/sram_dp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_dp_ctrl
//  Description : Dual-client controller for the 8192x32 dual-port SRAM macro.
//                Client 0 drives macro port A, client 1 drives macro port B.
//                All macro pins are registered. Client 1 is stalled when both
//                clients target the same address and either one writes.
//                Reads return with a fixed 2-cycle latency. After IDLE_CYCLES
//                idle cycles the macro is put in NAP; a request wakes it and
//                requests are held off for WAKE_CYCLES cycles.
//  Ports       : clk, rst           clock, async active-high reset
//                cli (slave)        client request/return bus
//                coll_cnt           saturating count of client-1 stalls
//                sram_cs*n/we*n     macro chip selects / write enables (low)
//                sram_a/b, dia/dib  macro addresses and write data
//                sram_nap           macro NAP control
//                sram_dvse, dvs     macro margin controls, tied off
//                sram_doa/dob       macro read data
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_dp_ctrl #(
    parameter int unsigned IDLE_CYCLES = 64,
    parameter int unsigned WAKE_CYCLES = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sram_dp_ctrl_if.slave    cli,
    output logic [15:0]      coll_cnt,
    output logic             sram_csan,
    output logic             sram_wean,
    output logic             sram_csbn,
    output logic             sram_webn,
    output logic [12:0]      sram_a,
    output logic [12:0]      sram_b,
    output logic [31:0]      sram_dia,
    output logic [31:0]      sram_dib,
    output logic             sram_nap,
    output logic             sram_dvse,
    output logic [3:0]       sram_dvs,
    input  wire logic [31:0] sram_doa,
    input  wire logic [31:0] sram_dob
);

    localparam logic [1:0]  c_st_active = 2'd0;
    localparam logic [1:0]  c_st_nap    = 2'd1;
    localparam logic [1:0]  c_st_wake   = 2'd2;

    localparam logic [31:0] c_idle_max  = 32'(IDLE_CYCLES);
    localparam logic [31:0] c_wake_last = 32'(WAKE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_idle_cnt;
    logic [31:0] r_wake_cnt;

    logic        w_ready0;
    logic        w_ready1;
    logic        w_coll;
    logic        w_acc0;
    logic        w_acc1;
    logic        w_idle;

    // Read tracking: p1 is set on the acceptance edge (macro pins loaded),
    // p2 on the edge the macro samples, rvalid on the edge sram_do* is taken.
    logic        r_rd0_p1;
    logic        r_rd0_p2;
    logic        r_rd1_p1;
    logic        r_rd1_p2;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    // Same-address access with at least one write; read/read is harmless.
    assign w_coll = cli.req0 && cli.req1 && (cli.addr0 == cli.addr1) &&
                    (cli.we0 || cli.we1);

    assign w_acc0 = cli.req0 && w_ready0;
    assign w_acc1 = cli.req1 && w_ready1;

    // A returning read (rvalid high) no longer counts as in flight, so the
    // idle count starts on the cycle the data is presented.
    assign w_idle = !cli.req0 && !cli.req1 &&
                    !r_rd0_p1 && !r_rd0_p2 && !r_rd1_p1 && !r_rd1_p2;

    always_comb begin
        w_state_nxt = r_state;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        case (r_state)
            c_st_active: begin
                w_ready0 = 1'b1;
                w_ready1 = !w_coll;
                if ((IDLE_CYCLES != 0) && w_idle && (r_idle_cnt == c_idle_max)) begin
                    w_state_nxt = c_st_nap;
                end
            end
            c_st_nap: begin
                if (cli.req0 || cli.req1) begin
                    w_state_nxt = c_st_wake;
                end
            end
            c_st_wake: begin
                if (r_wake_cnt == c_wake_last) begin
                    w_state_nxt = c_st_active;
                end
            end
            default: begin
                w_state_nxt = c_st_active;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_active;
            r_idle_cnt <= 32'd0;
            r_wake_cnt <= 32'd0;
            coll_cnt   <= 16'd0;
            sram_csan  <= 1'b1;
            sram_wean  <= 1'b1;
            sram_csbn  <= 1'b1;
            sram_webn  <= 1'b1;
            sram_a     <= 13'd0;
            sram_b     <= 13'd0;
            sram_dia   <= 32'd0;
            sram_dib   <= 32'd0;
            sram_nap   <= 1'b0;
            r_rd0_p1   <= 1'b0;
            r_rd0_p2   <= 1'b0;
            r_rd1_p1   <= 1'b0;
            r_rd1_p2   <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= 32'd0;
            r_rdata1   <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            sram_nap <= (w_state_nxt == c_st_nap);

            // Port A: address/data only move on an accepted request.
            sram_csan <= !w_acc0;
            sram_wean <= !(w_acc0 && cli.we0);
            if (w_acc0) begin
                sram_a   <= cli.addr0;
                sram_dia <= cli.wdata0;
            end

            // Port B.
            sram_csbn <= !w_acc1;
            sram_webn <= !(w_acc1 && cli.we1);
            if (w_acc1) begin
                sram_b   <= cli.addr1;
                sram_dib <= cli.wdata1;
            end

            r_rd0_p1  <= w_acc0 && !cli.we0;
            r_rd0_p2  <= r_rd0_p1;
            r_rvalid0 <= r_rd0_p2;
            if (r_rd0_p2) begin
                r_rdata0 <= sram_doa;
            end

            r_rd1_p1  <= w_acc1 && !cli.we1;
            r_rd1_p2  <= r_rd1_p1;
            r_rvalid1 <= r_rd1_p2;
            if (r_rd1_p2) begin
                r_rdata1 <= sram_dob;
            end

            // Counter stops at the threshold; the NAP transition clears it.
            if ((r_state == c_st_active) && w_idle && (r_idle_cnt != c_idle_max)) begin
                r_idle_cnt <= r_idle_cnt + 32'd1;
            end else begin
                r_idle_cnt <= 32'd0;
            end

            if (r_state == c_st_wake) begin
                r_wake_cnt <= r_wake_cnt + 32'd1;
            end else begin
                r_wake_cnt <= 32'd0;
            end

            if ((r_state == c_st_active) && w_coll && (coll_cnt != 16'hFFFF)) begin
                coll_cnt <= coll_cnt + 16'd1;
            end
        end
    end

    assign cli.ready0  = w_ready0;
    assign cli.ready1  = w_ready1;
    assign cli.rvalid0 = r_rvalid0;
    assign cli.rvalid1 = r_rvalid1;
    assign cli.rdata0  = r_rdata0;
    assign cli.rdata1  = r_rdata1;

    assign sram_dvse = 1'b0;
    assign sram_dvs  = 4'h0;

endmodule
`default_nettype wire

// File: doc/sram_dp_ctrl.md
# sram_dp_ctrl

Dual-client controller for the 8192x32 dual-port SRAM macro (SJLA40_8192X32X1CM8). Client 0 owns macro port A and client 1 owns macro port B. Each client uses a valid/ready handshake. The block registers all macro pins, stalls client 1 on same-address write hazards, and returns read data with fixed latency. It also places the macro in NAP after a programmable idle period and sequences the wake-up.

## Interface
- `IDLE_CYCLES`, default 64: number of consecutive idle cycles before NAP entry; 0 disables NAP.
- `WAKE_CYCLES`, default 4: number of cycles NAP is held low before requests are accepted again; minimum 1.
- `clk`  in  1: single clock; drives both CKA and CKB of the macro.
- `rst`  in  1: reset; asynchronous, active-high. The clock is one clock, `clk`.
- `req0`, `req1`  in  1: client request valid.
- `we0`, `we1`  in  1: 1 = write, 0 = read.
- `addr0`, `addr1`  in  13: word address.
- `wdata0`, `wdata1`  in  32: write data.
- `ready0`, `ready1`  out  1: request accepted this cycle when `req & ready`.
- `rvalid0`, `rvalid1`  out  1: one-cycle pulse; `rdata` is valid.
- `rdata0`, `rdata1`  out  32: read data.
- `coll_cnt`  out  16: saturating count of client-1 collision stalls.
- `sram_csan`, `sram_wean`, `sram_csbn`, `sram_webn`  out  1: macro chip selects and write enables, active-low, registered.
- `sram_a`, `sram_b`  out  13: macro addresses, registered.
- `sram_dia`, `sram_dib`  out  32: macro write data, registered.
- `sram_nap`  out  1: macro NAP, registered.
- `sram_dvse`  out  1: tied 0.
- `sram_dvs`  out  4: tied 4'h0.
- `sram_doa`, `sram_dob`  in  32: macro read data.

## Operation
- States: ACTIVE, NAP, WAKE. Reset state is ACTIVE.
- ACTIVE:
  - `ready0 = 1`.
  - `ready1 = !(req0 && req1 && addr0 == addr1 && (we0 || we1))`.
  - A stalled client 1 retries with unchanged request; client 0 always wins.
  - `coll_cnt` increments on each stall cycle and saturates at 16'hFFFF.
- Accepted request on port A: the next edge loads `sram_csan = 0`, `sram_wean = !we0`, `sram_a = addr0`, `sram_dia = wdata0`.
- No accepted request on port A: the next edge loads `sram_csan = 1` and `sram_wean = 1`; address and data hold their values.
- Port B behaves identically with client 1.
- Read tracking: a 2-stage valid pipeline per port captures `sram_do*` into `rdata*` and pulses `rvalid*`.
- Idle counter:
  - Increments each ACTIVE cycle with `req0 = req1 = 0` and no reads in flight.
  - Clears on any request.
  - At `IDLE_CYCLES` (nonzero), the next edge enters NAP: `sram_nap = 1`, CS deasserted, counter cleared.
- NAP: `ready0 = ready1 = 0`. Any `req` moves to WAKE on the next edge with `sram_nap = 0`.
- WAKE:
  - Ready outputs held at 0.
  - Counts `WAKE_CYCLES` cycles, then returns to ACTIVE.
  - Pending requests stay asserted by the clients and are accepted in the first ACTIVE cycle.
- Reset, asynchronous and effective mid-operation, drives:
  - all CS/WE outputs = 1, `sram_nap = 0`;
  - addresses and data = 0;
  - `rvalid` = 0, `rdata` = 0;
  - `coll_cnt` = 0, idle counter = 0, state ACTIVE.
  - In-flight reads are discarded and never return.

## Timing
- Request accepted at edge k. Macro pins change after edge k. The macro samples at edge k+1. `rdata`/`rvalid` are registered at edge k+2 and high during the cycle after edge k+2. Read latency is 2 cycles.
- Writes complete at edge k+1. A read of the same address accepted at edge k+1 or later returns the new data.
- Back-to-back acceptance on every cycle sustains one access per port per cycle.
- Ready outputs are combinational from state and inputs, with no dependency on `rvalid`.
- NAP entry: `sram_nap` rises exactly `IDLE_CYCLES + 1` edges after the last request or read return.
- Wake: from a request seen in NAP, first acceptance occurs `WAKE_CYCLES + 1` edges later.
- Simultaneous read/read to the same address is not a collision; both ports are accepted.

## Test plan
- Basic write/read: client 0 writes 32'h11111111 to address 1; one cycle later client 1 reads address 1 → `rvalid1` pulses 2 cycles after acceptance with `rdata1` = 32'h11111111.
- Collision: both clients request address 1 in the same cycle, client 0 writing 32'h11111111 and client 1 writing 32'h11110000 → `ready1 = 0` for one cycle and `coll_cnt = 1`. Client 1 writes next cycle, and a later read of address 1 returns 32'h11110000.
- Streaming: client 0 reads addresses 0..15 back-to-back after prefilling `data = addr` → 16 consecutive `rvalid0` pulses with rdata 0..15 in order, and `ready0` held high.
- NAP: with `IDLE_CYCLES = 8`, hold both clients idle → `sram_nap` rises 9 edges after the last read return. Then `req0` → `sram_nap` falls, and acceptance occurs after `WAKE_CYCLES + 1` edges.
- Reset mid-read: assert `rst` one cycle after a read is accepted → all outputs reach reset values asynchronously, and no `rvalid` occurs after release.
- Saturation: force 70000 collision cycles → `coll_cnt` holds at 16'hFFFF.
